// File: rtl/alarm_pkg.sv
// +--------------------------------------------------------------------+
// | alarm_pkg : shared state encoding, time widths and range limits     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package alarm_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 7;

  localparam logic [HOUR_W-1:0] HOURS_MAX   = 5'd23;
  localparam logic [MIN_W-1:0]  MINUTES_MAX = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RINGING  = 2'd2,
    ST_SNOOZING = 2'd3
  } state_e;

endpackage : alarm_pkg

`default_nettype wire

// File: rtl/time_add_minutes.sv
// +--------------------------------------------------------------------+
// | time_add_minutes : combinational hh:mm + offset (< 60 min) w/ wrap  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module time_add_minutes
  import alarm_pkg::*;
(
  input  logic [HOUR_W-1:0] hours,
  input  logic [MIN_W-1:0]  minutes,
  input  logic [MIN_W-1:0]  offset,
  output logic [HOUR_W-1:0] sum_hours,
  output logic [MIN_W-1:0]  sum_minutes
);

  logic [MIN_W:0] min_sum;
  logic           carry;

  // Offset is below 60, so at most one carry into the hour field.
  always_comb begin
    min_sum     = {1'b0, minutes} + {1'b0, offset};
    carry       = (min_sum > {1'b0, MINUTES_MAX});
    sum_minutes = carry ? 6'(min_sum - 7'd60) : min_sum[MIN_W-1:0];
    if (carry && (hours == HOURS_MAX)) begin
      sum_hours = '0;
    end else begin
      sum_hours = hours + {4'd0, carry};
    end
  end

endmodule : time_add_minutes

`default_nettype wire

// File: rtl/alarm_unit.sv
// +--------------------------------------------------------------------+
// | alarm_unit : programmable alarm with ring timeout; snooze support   |
// | compiled in with ALARM_SNOOZE_EN.                   Rev 1.0         |
// +--------------------------------------------------------------------+
`default_nettype none

module alarm_unit
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECONDS   = 60,
  parameter int unsigned SNOOZE_MINUTES = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEC_W-1:0]  seconds,
  input  logic [MIN_W-1:0]  minutes,
  input  logic [HOUR_W-1:0] hours,
  input  logic              set_valid,
  input  logic [HOUR_W-1:0] set_hours,
  input  logic [MIN_W-1:0]  set_minutes,
  output logic              set_ready,
  output logic              set_err,
  input  logic              arm,
  input  logic              stop,
  input  logic              snooze,
  output logic              ring,
  output logic [HOUR_W-1:0] alarm_hours,
  output logic [MIN_W-1:0]  alarm_minutes
);

  state_e            state_q, state_d;
  logic [HOUR_W-1:0] tgt_hours_q, tgt_hours_d;
  logic [MIN_W-1:0]  tgt_minutes_q, tgt_minutes_d;
  logic [SEC_W-1:0]  seconds_prev_q;
  logic [7:0]        ring_cnt_q, ring_cnt_d;
  logic              ring_q, ring_d;
  logic              set_err_q, set_err_d;

  logic              match, sec_change, write_acc, write_bad, timeout;
  logic              snooze_req;
  logic [HOUR_W-1:0] restore_hours, snz_hours;
  logic [MIN_W-1:0]  restore_minutes, snz_minutes;

  // Edge-qualified: only the cycle in which seconds rolls into 0 can match.
  assign match      = (hours == tgt_hours_q) && (minutes == tgt_minutes_q) &&
                      (seconds == '0) && (seconds_prev_q != '0);
  assign sec_change = (seconds != seconds_prev_q);
  assign set_ready  = (state_q == ST_IDLE) || (state_q == ST_ARMED);
  assign write_acc  = set_valid && set_ready;
  assign write_bad  = (set_hours > HOURS_MAX) || (set_minutes > MINUTES_MAX);
  assign timeout    = (ring_cnt_q == 8'(RING_SECONDS));

`ifdef ALARM_SNOOZE_EN
  logic [HOUR_W-1:0] prog_hours_q, prog_hours_d;
  logic [MIN_W-1:0]  prog_minutes_q, prog_minutes_d;

  time_add_minutes u_snooze_add (
    .hours       (tgt_hours_q),
    .minutes     (tgt_minutes_q),
    .offset      (6'(SNOOZE_MINUTES)),
    .sum_hours   (snz_hours),
    .sum_minutes (snz_minutes)
  );

  assign snooze_req      = snooze;
  assign restore_hours   = prog_hours_q;
  assign restore_minutes = prog_minutes_q;

  // The programmed time survives snoozes so stop can undo them.
  always_comb begin
    prog_hours_d   = prog_hours_q;
    prog_minutes_d = prog_minutes_q;
    if (write_acc && !write_bad) begin
      prog_hours_d   = set_hours;
      prog_minutes_d = set_minutes;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prog_hours_q   <= '0;
      prog_minutes_q <= '0;
    end else begin
      prog_hours_q   <= prog_hours_d;
      prog_minutes_q <= prog_minutes_d;
    end
  end
`else
  logic [8:0] unused_cfg;
  assign unused_cfg      = {snooze, 8'(SNOOZE_MINUTES)};
  assign snooze_req      = 1'b0;
  assign snz_hours       = tgt_hours_q;
  assign snz_minutes     = tgt_minutes_q;
  assign restore_hours   = tgt_hours_q;
  assign restore_minutes = tgt_minutes_q;
`endif

  always_comb begin
    state_d       = state_q;
    tgt_hours_d   = tgt_hours_q;
    tgt_minutes_d = tgt_minutes_q;
    ring_cnt_d    = ring_cnt_q;
    set_err_d     = 1'b0;

    if (write_acc) begin
      if (write_bad) begin
        set_err_d = 1'b1;
      end else begin
        tgt_hours_d   = set_hours;
        tgt_minutes_d = set_minutes;
      end
    end

    if (!arm) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARMED;
        ST_ARMED, ST_SNOOZING: begin
          if (match) begin
            state_d    = ST_RINGING;
            ring_cnt_d = '0;
          end
        end
        ST_RINGING: begin
          if (sec_change) ring_cnt_d = ring_cnt_q + 8'd1;
          if (stop) begin
            state_d       = ST_ARMED;
            tgt_hours_d   = restore_hours;
            tgt_minutes_d = restore_minutes;
          end else if (snooze_req) begin
            state_d       = ST_SNOOZING;
            tgt_hours_d   = snz_hours;
            tgt_minutes_d = snz_minutes;
          end else if (timeout) begin
            state_d = ST_ARMED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    ring_d = (state_d == ST_RINGING);
  end

  always_ff @(posedge clk) begin
    seconds_prev_q <= seconds;
    if (reset) begin
      state_q       <= ST_IDLE;
      tgt_hours_q   <= '0;
      tgt_minutes_q <= '0;
      ring_cnt_q    <= '0;
      ring_q        <= 1'b0;
      set_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tgt_hours_q   <= tgt_hours_d;
      tgt_minutes_q <= tgt_minutes_d;
      ring_cnt_q    <= ring_cnt_d;
      ring_q        <= ring_d;
      set_err_q     <= set_err_d;
    end
  end

  assign ring          = ring_q;
  assign set_err       = set_err_q;
  assign alarm_hours   = tgt_hours_q;
  assign alarm_minutes = tgt_minutes_q;

endmodule : alarm_unit

`default_nettype wire

// File: tb/tb_alarm_unit.sv
// +--------------------------------------------------------------------+
// | tb_alarm_unit : directed and randomized checks of alarm_unit        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_alarm_unit;

  localparam int RING_SEC   = 3;
  localparam int SNOOZE_MIN = 5;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNOOZE_ON = 1'b1;
`else
  localparam bit SNOOZE_ON = 1'b0;
`endif

  localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_SNOOZED = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seconds = '0;
  logic [5:0] minutes = '0;
  logic [4:0] hours = '0;
  logic       set_valid = 1'b0;
  logic [4:0] set_hours = '0;
  logic [5:0] set_minutes = '0;
  logic       set_ready, set_err, ring;
  logic       arm = 1'b0, stop = 1'b0, snooze = 1'b0;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;

  int total = 0;
  int bad   = 0;

  // Reference state: alarm targets held as minute-of-day (0..1439).
  int m_mode = M_IDLE;
  int m_tgt  = 0;
  int m_prog = 0;
  int m_chg  = 0;
  int m_prev = 0;
  bit m_err  = 1'b0;

  alarm_unit #(.RING_SECONDS(RING_SEC), .SNOOZE_MINUTES(SNOOZE_MIN)) dut (
    .clk(clk), .reset(reset), .seconds(seconds), .minutes(minutes), .hours(hours),
    .set_valid(set_valid), .set_hours(set_hours), .set_minutes(set_minutes),
    .set_ready(set_ready), .set_err(set_err), .arm(arm), .stop(stop), .snooze(snooze),
    .ring(ring), .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit hit, chg, ready, wr, inval;
    int nmode, ntgt, nprog, nchg;
    if (reset) begin
      m_mode = M_IDLE; m_tgt = 0; m_prog = 0; m_chg = 0; m_err = 1'b0;
      m_prev = int'(seconds);
      return;
    end
    hit   = (int'(hours) * 60 + int'(minutes) == m_tgt) && (seconds == 0) && (m_prev != 0);
    chg   = (int'(seconds) != m_prev);
    ready = (m_mode == M_IDLE) || (m_mode == M_ARMED);
    wr    = set_valid && ready;
    inval = (set_hours > 23) || (set_minutes > 59);
    nmode = m_mode; ntgt = m_tgt; nprog = m_prog; nchg = m_chg;
    if (wr && !inval) begin
      ntgt  = int'(set_hours) * 60 + int'(set_minutes);
      nprog = ntgt;
    end
    if (!arm) nmode = M_IDLE;
    else if (m_mode == M_IDLE) nmode = M_ARMED;
    else if (m_mode == M_RING) begin
      if (chg) nchg = m_chg + 1;
      if (stop) begin
        nmode = M_ARMED; ntgt = m_prog;
      end else if (snooze && SNOOZE_ON) begin
        nmode = M_SNOOZED; ntgt = (m_tgt + SNOOZE_MIN) % 1440;
      end else if (m_chg >= RING_SEC) begin
        nmode = M_ARMED;
      end
    end else if (hit) begin
      nmode = M_RING; nchg = 0;
    end
    m_mode = nmode; m_tgt = ntgt; m_prog = nprog; m_chg = nchg;
    m_err  = wr && inval;
    m_prev = int'(seconds);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hours = 5'(h); minutes = 6'(m); seconds = 7'(s);
  endtask

  task automatic write_target(input int h, input int m);
    set_valid = 1'b1; set_hours = 5'(h); set_minutes = 6'(m);
    tick();
    set_valid = 1'b0;
  endtask

  task automatic ring_up(input int h, input int m);
    arm = 1'b1;
    set_time(h, m, 59); tick();
    set_time(h, m, 0);  tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL reset_ring: got %0b want 0", ring); end
    total++; if (set_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", set_ready); end
    total++; if (set_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", set_err); end
    total++; if ({alarm_hours, alarm_minutes} !== 11'd0) begin bad++;
      $display("FAIL reset_target: got %0d:%0d want 0:0", alarm_hours, alarm_minutes); end
  endtask

  task automatic test_match_and_stop();
    write_target(7, 30);
    total++; if (alarm_hours !== 5'd7 || alarm_minutes !== 6'd30) begin bad++;
      $display("FAIL write_target: got %0d:%0d want 7:30", alarm_hours, alarm_minutes); end
    total++; if (set_err !== 1'b0) begin bad++; $display("FAIL write_err: got %0b want 0", set_err); end
    arm = 1'b1; set_time(7, 29, 59); tick(); tick();
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL pre_match_ring: got %0b want 0", ring); end
    set_time(7, 30, 0); tick();
    total++; if (ring !== 1'b1) begin bad++; $display("FAIL match_ring: got %0b want 1", ring); end
    stop = 1'b1; tick(); stop = 1'b0;
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL stop_ring: got %0b want 0", ring); end
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (ring !== 1'b0) begin bad++; $display("FAIL hold_no_retrigger: cycle %0d ring=%0b want 0", i, ring); end
    end
  endtask

  task automatic test_timeout();
    ring_up(7, 30);
    for (int s = 1; s <= RING_SEC; s++) begin
      set_time(7, 30, s); tick();
      total++; if (ring !== 1'b1) begin bad++; $display("FAIL timeout_still_ring: sec %0d ring=%0b want 1", s, ring); end
    end
    // Counter now holds RING_SEC; the next edge leaves RINGING.
    tick();
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL timeout_ring: got %0b want 0", ring); end
    total++; if (set_ready !== 1'b1) begin bad++; $display("FAIL timeout_armed_ready: got %0b want 1", set_ready); end
  endtask

  task automatic test_set_err();
    write_target(24, 10);
    total++; if (set_err !== 1'b1) begin bad++; $display("FAIL bad_hour_err: got %0b want 1", set_err); end
    total++; if (alarm_hours !== 5'd7 || alarm_minutes !== 6'd30) begin bad++;
      $display("FAIL bad_hour_target: got %0d:%0d want 7:30", alarm_hours, alarm_minutes); end
    tick();
    total++; if (set_err !== 1'b0) begin bad++; $display("FAIL err_one_cycle: got %0b want 0", set_err); end
    write_target(10, 60);
    total++; if (set_err !== 1'b1) begin bad++; $display("FAIL bad_min_err: got %0b want 1", set_err); end
    ring_up(7, 30);
    total++; if (set_ready !== 1'b0) begin bad++; $display("FAIL ring_ready: got %0b want 0", set_ready); end
    write_target(12, 0);
    total++; if (alarm_hours !== 5'd7 || alarm_minutes !== 6'd30 || set_err !== 1'b0) begin bad++;
      $display("FAIL ring_write_ignored: got %0d:%0d err=%0b want 7:30 err=0", alarm_hours, alarm_minutes, set_err); end
  endtask

  task automatic test_stop_and_snooze_same();
    stop = 1'b1; snooze = 1'b1; tick(); stop = 1'b0; snooze = 1'b0;
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL stop_wins_ring: got %0b want 0", ring); end
    total++; if (alarm_hours !== 5'd7 || alarm_minutes !== 6'd30) begin bad++;
      $display("FAIL stop_wins_target: got %0d:%0d want 7:30", alarm_hours, alarm_minutes); end
  endtask

  task automatic test_disarm();
    ring_up(7, 30);
    total++; if (ring !== 1'b1) begin bad++; $display("FAIL disarm_pre_ring: got %0b want 1", ring); end
    arm = 1'b0; tick();
    total++; if (ring !== 1'b0 || set_ready !== 1'b1) begin bad++;
      $display("FAIL disarm: ring=%0b ready=%0b want ring=0 ready=1", ring, set_ready); end
    arm = 1'b1; tick();
  endtask

  task automatic test_snooze();
    write_target(23, 58);
    ring_up(23, 58);
    total++; if (ring !== 1'b1) begin bad++; $display("FAIL snooze_pre_ring: got %0b want 1", ring); end
    snooze = 1'b1; tick(); snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
    total++; if (ring !== 1'b0 || alarm_hours !== 5'd0 || alarm_minutes !== 6'd3) begin bad++;
      $display("FAIL snooze_retarget: ring=%0b tgt=%0d:%0d want ring=0 0:3", ring, alarm_hours, alarm_minutes); end
    set_time(0, 2, 59); tick();
    set_time(0, 3, 0);  tick();
    total++; if (ring !== 1'b1) begin bad++; $display("FAIL snooze_rering: got %0b want 1", ring); end
`else
    total++; if (ring !== 1'b1 || alarm_hours !== 5'd23 || alarm_minutes !== 6'd58) begin bad++;
      $display("FAIL snooze_noop: ring=%0b tgt=%0d:%0d want ring=1 23:58", ring, alarm_hours, alarm_minutes); end
`endif
    stop = 1'b1; tick(); stop = 1'b0;
    total++; if (ring !== 1'b0 || alarm_hours !== 5'd23 || alarm_minutes !== 6'd58) begin bad++;
      $display("FAIL snooze_stop_restore: ring=%0b tgt=%0d:%0d want ring=0 23:58", ring, alarm_hours, alarm_minutes); end
  endtask

  task automatic test_reset_mid_ring();
    ring_up(23, 58);
    total++; if (ring !== 1'b1) begin bad++; $display("FAIL rst_pre_ring: got %0b want 1", ring); end
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if (ring !== 1'b0 || set_ready !== 1'b1 || {alarm_hours, alarm_minutes} !== 11'd0) begin bad++;
      $display("FAIL rst_mid_ring: ring=%0b ready=%0b tgt=%0d:%0d want 0 1 0:0", ring, set_ready, alarm_hours, alarm_minutes); end
  endtask

  task automatic test_random();
    int sel;
    for (int i = 0; i < 2000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      arm       = ($urandom_range(0, 49) != 0);
      stop      = ($urandom_range(0, 19) == 0);
      snooze    = ($urandom_range(0, 11) == 0);
      set_valid = ($urandom_range(0, 15) == 0);
      set_hours   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 1));
      set_minutes = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 6));
      hours   = 5'($urandom_range(0, 1));
      minutes = 6'($urandom_range(0, 6));
      sel = int'($urandom_range(0, 3));
      if (sel == 0) seconds = 7'd0;
      else if (sel == 1) seconds = 7'd59;
      else if (sel == 3) seconds = 7'($urandom_range(0, 59));
      tick();
      total++; if (ring !== (m_mode == M_RING)) begin bad++;
        $display("FAIL rand_ring: cycle %0d got %0b want %0b", i, ring, (m_mode == M_RING)); end
      total++; if (set_ready !== (m_mode == M_IDLE || m_mode == M_ARMED)) begin bad++;
        $display("FAIL rand_ready: cycle %0d got %0b want %0b", i, set_ready, (m_mode == M_IDLE || m_mode == M_ARMED)); end
      total++; if (set_err !== m_err) begin bad++;
        $display("FAIL rand_err: cycle %0d got %0b want %0b", i, set_err, m_err); end
      total++; if (int'(alarm_hours) != m_tgt / 60 || int'(alarm_minutes) != m_tgt % 60) begin bad++;
        $display("FAIL rand_target: cycle %0d got %0d:%0d want %0d:%0d", i, alarm_hours, alarm_minutes, m_tgt / 60, m_tgt % 60); end
    end
    reset = 1'b0; stop = 1'b0; snooze = 1'b0; set_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_match_and_stop();
    test_timeout();
    test_set_err();
    test_stop_and_snooze_same();
    test_disarm();
    test_snooze();
    test_reset_mid_ring();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alarm_unit

`default_nettype wire

// File: doc/alarm_unit.md
# alarm_unit

Alarm stage sitting directly downstream of the hours/minutes/seconds counter chain. Consumes the running time, holds a user-programmed alarm time, and raises `ring` when the running time reaches it. Ringing ends on stop, on timeout, or on disarm. With the snooze option compiled in, a snooze request re-targets the alarm a fixed number of minutes later.

## Interface
- `RING_SECONDS`, 60: number of seconds transitions `ring` stays high before auto-stop; range 1..255.
- `SNOOZE_MINUTES`, 5: snooze offset in minutes; range 1..59.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `seconds`  in  7  running seconds, 0..59, from the counter chain.
- `minutes`  in  6  running minutes, 0..59.
- `hours`  in  5  running hours, 0..23.
- `set_valid`  in  1  alarm-time write request.
- `set_hours`  in  5  requested alarm hour.
- `set_minutes`  in  6  requested alarm minute.
- `set_ready`  out  1  write accepted when `set_valid && set_ready`.
- `set_err`  out  1  one-cycle pulse: the accepted write was out of range and was discarded.
- `arm`  in  1  level; alarm is enabled while high.
- `stop`  in  1  one-cycle pulse; silences the alarm.
- `snooze`  in  1  one-cycle pulse; ignored when `ALARM_SNOOZE_EN` is undefined.
- `ring`  out  1  alarm active.
- `alarm_hours`  out  5  current target hour, including any snooze offset.
- `alarm_minutes`  out  6  current target minute.

## Operation
- Reset values: state IDLE, target 00:00, `ring`=0, `set_err`=0, `set_ready`=1, ring counter 0.
- States and transitions:
  - IDLE → ARMED when `arm`=1.
  - ARMED → RINGING on a match.
  - RINGING → ARMED on `stop`, or when the ring counter reaches `RING_SECONDS`.
  - RINGING → SNOOZING on `snooze`.
  - SNOOZING → RINGING on a match.
  - Any state → IDLE when `arm`=0; this has top priority.
- Match condition: `hours`==target hour, `minutes`==target minute, `seconds`==0, and the registered previous `seconds`≠0. A match is edge-qualified, so it fires once per occurrence even if the input time holds.
- Alarm-time writes:
  - Accepted only in IDLE or ARMED; `set_ready`=0 in RINGING and SNOOZING.
  - An accepted write with hour>23 or minute>59 leaves the target unchanged and pulses `set_err`.
  - A valid write replaces the target and also discards any snooze offset.
- Snooze:
  - Target becomes target + `SNOOZE_MINUTES`, minute wrap 59→0 carries into the hour, hour wrap 23→0.
  - Example: 23:58 + 5 → 00:03.
  - The snooze offset accumulates on repeated snoozes.
  - `stop` from RINGING restores the originally programmed time.
- Ring counter:
  - Cleared on entry to RINGING.
  - Increments on every change of `seconds` (registered compare).
- Simultaneous events in RINGING, highest priority first: `arm` low, `stop`, `snooze`, timeout.
- A match while a write is being accepted in ARMED is evaluated against the old target.

## Timing
- `ring` is registered: it rises the cycle after the match is detected and falls the cycle after `stop`, `snooze`, timeout, or `arm`=0.
- A write accepted on edge N is visible on `alarm_*` after edge N; `set_err` is high for exactly that one cycle.
- Snooze re-target latency is 1 cycle.
- A reset asserted mid-ring clears `ring` on the next edge.

## Configuration
- `ALARM_SNOOZE_EN` defined:
  - SNOOZING state, the snooze adder, and the original-target register are present.
- `ALARM_SNOOZE_EN` undefined:
  - `snooze` input is ignored; it is treated as a no-op with no state change.
  - No SNOOZING state exists.
  - `SNOOZE_MINUTES` is unused.
  - `stop` is the only user exit from RINGING.

## Structure
- Package `alarm_pkg`:
  - state enum (IDLE, ARMED, RINGING, SNOOZING).
  - constants HOURS_MAX=23, MINUTES_MAX=59.
  - widths HOUR_W=5, MIN_W=6, SEC_W=7.
- Sub-module `time_add_minutes`: combinational hour:minute + offset with wrap.
  - Instantiated only under `ALARM_SNOOZE_EN`.
  - Verifiable standalone.

## Test plan
- Target 07:30, arm=1, drive time 07:29:59 → 07:30:00: `ring`=1 one cycle after 07:30:00 appears. Hold 07:30:00 for 10 cycles → no retrigger after `stop`.
- Ringing with `RING_SECONDS`=3, step seconds 0→1→2→3: `ring` drops after the third change; state returns to ARMED.
- Write 24:10: `set_err` pulses once, `alarm_hours`/`alarm_minutes` unchanged. Write during RINGING: `set_ready`=0, nothing captured.
- With `ALARM_SNOOZE_EN`, target 23:58:
  - `snooze` while ringing → `alarm_*`=00:03, `ring`=0.
  - Match at 00:03:00 re-rings.
  - `stop` → target back to 23:58.
- `stop` and `snooze` asserted in the same cycle while ringing → stop wins, target unchanged. `arm`=0 while ringing → `ring`=0 next cycle, state IDLE.
- `reset` pulsed while ringing → `ring`=0, target 00:00, `set_ready`=1 after the edge.
